// File: rtl/alu_issue_if.sv
// alu_issue_if: bundle for the ALU issue stage.
//   Request side : req_valid/req_ready handshake, req_rd/rn/rm, req_shift,
//                  req_aluop, req_wb.
//   Load side    : ld_valid/ld_num/ld_data (direct register-file write).
//   ALU side     : Ain/Bin/ALUop out to the ALU, alu_out/alu_z back in.
//   Results      : C, status_z, done.
// The master modport is the environment around the stage (requester and
// the combinational ALU); the slave modport is the stage itself.
interface alu_issue_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3
);
  logic              req_valid;
  logic              req_ready;
  logic [IDX_W-1:0]  req_rd;
  logic [IDX_W-1:0]  req_rn;
  logic [IDX_W-1:0]  req_rm;
  logic [1:0]        req_shift;
  logic [1:0]        req_aluop;
  logic              req_wb;
  logic              ld_valid;
  logic [IDX_W-1:0]  ld_num;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] Ain;
  logic [DATA_W-1:0] Bin;
  logic [1:0]        ALUop;
  logic [DATA_W-1:0] alu_out;
  logic              alu_z;
  logic [DATA_W-1:0] C;
  logic              status_z;
  logic              done;

  modport master (
    output req_valid, req_rd, req_rn, req_rm, req_shift, req_aluop, req_wb,
    output ld_valid, ld_num, ld_data, alu_out, alu_z,
    input  req_ready, Ain, Bin, ALUop, C, status_z, done
  );

  modport slave (
    input  req_valid, req_rd, req_rn, req_rm, req_shift, req_aluop, req_wb,
    input  ld_valid, ld_num, ld_data, alu_out, alu_z,
    output req_ready, Ain, Bin, ALUop, C, status_z, done
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand fetch / writeback stage around a combinational ALU.
// Holds a REG_N-entry register file. One operation runs at a time through
// IDLE -> RDA -> RDB -> EXEC -> WB, one cycle per non-IDLE state.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : alu_issue_if.slave (request, load, ALU and result signals)
// Build option: define ALU_ISSUE_SHIFT_EN to include the B-operand shifter;
// without it req_shift is ignored and B is R[rm] unmodified.
module alu_issue_stage #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8
) (
  input  logic        clk,
  input  logic        reset,
  alu_issue_if.slave  bus
);
  localparam int IDX_W = $clog2(REG_N);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RDA  = 3'd1;
  localparam logic [2:0] S_RDB  = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;

  logic [2:0]        state;
  logic [DATA_W-1:0] rf [REG_N];
  logic [DATA_W-1:0] a_q, b_q, c_q;
  logic              z_q;
  logic [1:0]        aluop_q;
  logic [IDX_W-1:0]  rd_q, rn_q, rm_q;
  logic              wb_q;
  logic [DATA_W-1:0] rm_val, b_next;
`ifdef ALU_ISSUE_SHIFT_EN
  logic [1:0]        shift_q;
`endif

  assign rm_val = rf[rm_q];

  always_comb begin
    b_next = rm_val;
`ifdef ALU_ISSUE_SHIFT_EN
    case (shift_q)
      2'b01:   b_next = {rm_val[DATA_W-2:0], 1'b0};
      2'b10:   b_next = {1'b0, rm_val[DATA_W-1:1]};
      2'b11:   b_next = {rm_val[DATA_W-1], rm_val[DATA_W-1:1]};
      default: b_next = rm_val;
    endcase
`endif
  end

  // A pending load blocks acceptance so the request sees the loaded value.
  assign bus.req_ready = (state == S_IDLE) & ~bus.ld_valid;
  assign bus.done      = (state == S_WB);
  assign bus.Ain       = a_q;
  assign bus.Bin       = b_q;
  assign bus.ALUop     = aluop_q;
  assign bus.C         = c_q;
  assign bus.status_z  = z_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      for (int i = 0; i < REG_N; i++) rf[i] <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      z_q     <= 1'b0;
      aluop_q <= 2'b00;
      rd_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      wb_q    <= 1'b0;
`ifdef ALU_ISSUE_SHIFT_EN
      shift_q <= 2'b00;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.ld_valid) begin
            rf[bus.ld_num] <= bus.ld_data;
          end else if (bus.req_valid) begin
            rd_q    <= bus.req_rd;
            rn_q    <= bus.req_rn;
            rm_q    <= bus.req_rm;
            aluop_q <= bus.req_aluop;
            wb_q    <= bus.req_wb;
`ifdef ALU_ISSUE_SHIFT_EN
            shift_q <= bus.req_shift;
`endif
            state   <= S_RDA;
          end
        end
        S_RDA: begin
          a_q   <= rf[rn_q];
          state <= S_RDB;
        end
        S_RDB: begin
          b_q   <= b_next;
          state <= S_EXEC;
        end
        S_EXEC: begin
          c_q   <= bus.alu_out;
          z_q   <= bus.alu_z;
          state <= S_WB;
        end
        S_WB: begin
          if (wb_q) rf[rd_q] <= c_q;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
